// File: rtl/mem_map_pkg.sv
// Shared memory map: I/O window offsets, register indices and RAM sizing.
package mem_map_pkg;

    localparam int unsigned RAM_WORDS_DEFAULT = 4096;
    localparam logic [15:0] IO_BASE_DEFAULT   = 16'hF000;

    // Byte offsets of the I/O registers from IO_BASE
    localparam logic [15:0] IO_LED_OFS = 16'h0000;
    localparam logic [15:0] IO_SW_OFS  = 16'h0002;
    localparam logic [15:0] IO_CNT_OFS = 16'h0004;
    localparam logic [15:0] IO_CTL_OFS = 16'h0006;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SW,
        REG_CNT,
        REG_CTL
    } reg_idx_e;

    // Map a byte address onto an I/O register; bit 0 is ignored
    function automatic reg_idx_e io_decode(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] ofs;
        reg_idx_e    idx;
        ofs = (addr - base) & 16'hFFFE;
        case (ofs)
            IO_LED_OFS: idx = REG_LED;
            IO_SW_OFS:  idx = REG_SW;
            IO_CNT_OFS: idx = REG_CNT;
            IO_CTL_OFS: idx = REG_CTL;
            default:    idx = REG_NONE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ram_1rw_sync.sv
// Single-port 16-bit RAM: synchronous read, read-before-write, no reset.
module ram_1rw_sync #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [WORDS];

    // Registered read returns the old word when a write hits the same address
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder: RAM, LED/switch/counter I/O window and program loader.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_WORDS = RAM_WORDS_DEFAULT,
    parameter logic [15:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_addr,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_mem_wrdata,
    output logic [15:0] o_mem_rddata,
    input  logic        i_load_en,
    input  logic [15:0] i_load_addr,
    input  logic [15:0] i_load_data,
    input  logic [15:0] i_sw,
    output logic [15:0] o_led
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam int unsigned RAM_BYTES = 2 * RAM_WORDS;

    logic          cpu_rd;
    logic          cpu_wr;
    logic          cpu_in_ram;
    logic          load_in_ram;
    reg_idx_e      cpu_reg;
    logic [15:0]   io_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;

    logic          rd_valid_q;
    logic          rd_ram_q;
    logic [15:0]   io_rd_q;
    logic [15:0]   last_q;
    logic [15:0]   rd_resp;
    logic [15:0]   led_q;
    logic [15:0]   cnt_q;
    logic [15:0]   sw_sync1;
    logic [15:0]   sw_sync2;

    // Request qualification and address decode; the loader masks the CPU port
    always_comb begin
        cpu_rd      = i_mem_rd & ~i_load_en;
        cpu_wr      = i_mem_wr & ~i_load_en;
        cpu_in_ram  = 32'(i_mem_addr) < RAM_BYTES;
        load_in_ram = 32'(i_load_addr) < RAM_BYTES;
        cpu_reg     = cpu_in_ram ? REG_NONE : io_decode(i_mem_addr, IO_BASE);
        case (cpu_reg)
            REG_LED: io_rdata = led_q;
            REG_SW:  io_rdata = sw_sync2;
            REG_CNT: io_rdata = cnt_q;
            default: io_rdata = '0;
        endcase
    end

    // RAM port steering; reset suppresses any access on the same edge
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = i_mem_addr[AW:1];
        ram_wdata = i_mem_wrdata;
        if (!reset) begin
            if (i_load_en) begin
                ram_en    = load_in_ram;
                ram_we    = load_in_ram;
                ram_addr  = i_load_addr[AW:1];
                ram_wdata = i_load_data;
            end else begin
                ram_en = (cpu_rd | cpu_wr) & cpu_in_ram;
                ram_we = cpu_wr & cpu_in_ram;
            end
        end
    end

    ram_1rw_sync #(
        .WORDS(RAM_WORDS),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // I/O registers: LED, switch synchronizer, free-running counter (clear wins)
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '0;
            cnt_q    <= '0;
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= i_sw;
            sw_sync2 <= sw_sync1;
            if (cpu_wr && cpu_reg == REG_CTL && i_mem_wrdata[0]) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (cpu_wr && cpu_reg == REG_LED) begin
                led_q <= i_mem_wrdata;
            end
        end
    end

    // Read pipeline: RAM data arrives from the RAM's own output register, so
    // I/O data is registered alongside it and the response is muxed after;
    // last_q keeps the response stable once the read slot has passed
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_ram_q   <= 1'b0;
            io_rd_q    <= '0;
            last_q     <= '0;
        end else begin
            if (rd_valid_q) begin
                last_q <= rd_resp;
            end
            rd_valid_q <= cpu_rd;
            rd_ram_q   <= cpu_in_ram;
            io_rd_q    <= io_rdata;
        end
    end

    // Response mux
    always_comb begin
        rd_resp = last_q;
        if (rd_valid_q) begin
            rd_resp = rd_ram_q ? ram_rdata : io_rd_q;
        end
    end

    assign o_mem_rddata = rd_resp;
    assign o_led        = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder.
module tb_mem_responder;

    localparam logic [15:0] IOB = 16'hF000;

    logic        clk;
    logic        reset;
    logic [15:0] i_mem_addr;
    logic        i_mem_rd;
    logic        i_mem_wr;
    logic [15:0] i_mem_wrdata;
    logic [15:0] o_mem_rddata;
    logic        i_load_en;
    logic [15:0] i_load_addr;
    logic [15:0] i_load_data;
    logic [15:0] i_sw;
    logic [15:0] o_led;

    int unsigned n_vec;
    int unsigned n_bad;

    mem_responder #(
        .RAM_WORDS(4096),
        .IO_BASE  (IOB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rd    (i_mem_rd),
        .i_mem_wr    (i_mem_wr),
        .i_mem_wrdata(i_mem_wrdata),
        .o_mem_rddata(o_mem_rddata),
        .i_load_en   (i_load_en),
        .i_load_addr (i_load_addr),
        .i_load_data (i_load_data),
        .i_sw        (i_sw),
        .o_led       (o_led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        i_mem_addr   = a;
        i_mem_wrdata = d;
        i_mem_wr     = 1'b1;
        @(negedge clk);
        i_mem_wr     = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        i_mem_addr = a;
        i_mem_rd   = 1'b1;
        @(negedge clk);
        i_mem_rd   = 1'b0;
        check(tag, o_mem_rddata, exp);
    endtask

    task automatic cpu_rdwr(input string tag, input logic [15:0] a, input logic [15:0] d,
                            input logic [15:0] exp);
        i_mem_addr   = a;
        i_mem_wrdata = d;
        i_mem_rd     = 1'b1;
        i_mem_wr     = 1'b1;
        @(negedge clk);
        i_mem_rd     = 1'b0;
        i_mem_wr     = 1'b0;
        check(tag, o_mem_rddata, exp);
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        reset        = 1'b0;
        i_mem_addr   = '0;
        i_mem_rd     = 1'b0;
        i_mem_wr     = 1'b0;
        i_mem_wrdata = '0;
        i_load_en    = 1'b0;
        i_load_addr  = '0;
        i_load_data  = '0;
        i_sw         = '0;

        // Reset
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_rddata", o_mem_rddata, 16'h0000);
        check("rst_led", o_led, 16'h0000);

        // Counter: read sampled on the 11th edge after reset returns 10
        repeat (10) @(negedge clk);
        cpu_read("cnt_at_10", IOB + 16'h4, 16'd10);
        @(negedge clk);
        check("hold_idle", o_mem_rddata, 16'd10);

        // Counter clear, non-clear control write, control reads 0
        cpu_write(IOB + 16'h6, 16'h0001);
        cpu_read("cnt_clr0", IOB + 16'h4, 16'd0);
        cpu_read("cnt_clr1", IOB + 16'h4, 16'd1);
        cpu_write(IOB + 16'h6, 16'h0002);
        cpu_read("cnt_noclr", IOB + 16'h4, 16'd3);
        cpu_read("ctl_rd0", IOB + 16'h6, 16'h0000);

        // RAM write then read, odd address aliases the same word
        cpu_write(16'h0010, 16'hBEEF);
        cpu_read("ram_wr_rd", 16'h0010, 16'hBEEF);
        cpu_read("ram_odd", 16'h0011, 16'hBEEF);

        // Simultaneous read and write returns old data
        cpu_write(16'h0020, 16'h1234);
        cpu_rdwr("rdwr_old", 16'h0020, 16'h5678, 16'h1234);
        cpu_read("rdwr_new", 16'h0020, 16'h5678);

        // LED
        cpu_write(IOB, 16'h00A5);
        check("led_out", o_led, 16'h00A5);
        cpu_read("led_rd", IOB, 16'h00A5);

        // Switch synchronizer
        i_sw = 16'h0F0F;
        repeat (3) @(negedge clk);
        cpu_read("sw_settled", IOB + 16'h2, 16'h0F0F);
        i_sw = 16'h00FF;
        cpu_read("sw_lat1", IOB + 16'h2, 16'h0F0F);
        cpu_read("sw_lat2", IOB + 16'h2, 16'h0F0F);
        cpu_read("sw_lat3", IOB + 16'h2, 16'h00FF);

        // Unmapped addresses and RAM upper boundary
        cpu_read("unmapped_4000", 16'h4000, 16'h0000);
        cpu_read("unmapped_io8", IOB + 16'h8, 16'h0000);
        cpu_write(16'h1FFE, 16'hCAFE);
        cpu_read("ram_top", 16'h1FFE, 16'hCAFE);
        cpu_write(16'h0000, 16'h7777);
        cpu_write(16'h2000, 16'h9999);
        cpu_read("oob_rd", 16'h2000, 16'h0000);
        cpu_read("oob_no_alias", 16'h0000, 16'h7777);

        // Loader: CPU write and read ignored, output held, out-of-range load dropped
        i_load_en    = 1'b1;
        i_load_addr  = 16'h0000;
        i_load_data  = 16'h1111;
        i_mem_addr   = 16'h0000;
        i_mem_wrdata = 16'hDEAD;
        i_mem_wr     = 1'b1;
        @(negedge clk);
        i_mem_wr    = 1'b0;
        i_mem_rd    = 1'b1;
        i_load_addr = 16'h0002;
        i_load_data = 16'h2222;
        @(negedge clk);
        i_mem_rd    = 1'b0;
        check("load_hold", o_mem_rddata, 16'h7777);
        i_load_addr = 16'h2000;
        i_load_data = 16'hBAD0;
        @(negedge clk);
        i_load_en = 1'b0;
        check("load_hold2", o_mem_rddata, 16'h7777);
        cpu_read("load_w0", 16'h0000, 16'h1111);
        cpu_read("load_w1", 16'h0002, 16'h2222);

        // Reset the cycle after a read; a LED write on the reset edge is dropped
        i_mem_addr = 16'h0010;
        i_mem_rd   = 1'b1;
        @(negedge clk);
        i_mem_rd     = 1'b0;
        reset        = 1'b1;
        i_mem_addr   = IOB;
        i_mem_wrdata = 16'h5555;
        i_mem_wr     = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        i_mem_wr = 1'b0;
        check("mid_rst_rddata", o_mem_rddata, 16'h0000);
        check("mid_rst_led", o_led, 16'h0000);
        cpu_read("mid_rst_cnt", IOB + 16'h4, 16'd0);
        cpu_read("ram_keep0", 16'h0002, 16'h2222);
        cpu_read("ram_keep1", 16'h0010, 16'hBEEF);

        // Counter wrap: clear at edge C, read at C+65536 -> FFFF, C+65537 -> 0000
        cpu_write(IOB + 16'h6, 16'h0001);
        repeat (65535) @(negedge clk);
        cpu_read("cnt_ffff", IOB + 16'h4, 16'hFFFF);
        cpu_read("cnt_wrap", IOB + 16'h4, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, giving the number of 16-bit RAM words (power of two, at most 16384).
REQ-002 SHALL have parameter IO_BASE, default 16'hF000, giving the base address of the I/O register window.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_mem_addr, input, 16 bits: CPU byte address; bit 0 is ignored.
REQ-006 SHALL have port i_mem_rd, input, 1 bit: CPU read request.
REQ-007 SHALL have port i_mem_wr, input, 1 bit: CPU write request.
REQ-008 SHALL have port i_mem_wrdata, input, 16 bits: CPU write data.
REQ-009 SHALL have port o_mem_rddata, output, 16 bits: read response to the CPU.
REQ-010 SHALL have port i_load_en, input, 1 bit: program-loader mode.
REQ-011 SHALL have port i_load_addr, input, 16 bits: loader byte address.
REQ-012 SHALL have port i_load_data, input, 16 bits: loader write data.
REQ-013 SHALL have port i_sw, input, 16 bits: asynchronous switch inputs.
REQ-014 SHALL have port o_led, output, 16 bits: LED register value.

Function
REQ-015 SHALL decode addresses as follows:
- RAM: addresses below 2*RAM_WORDS; word index is addr[15:1].
- IO_BASE+0: LED register, read/write.
- IO_BASE+2: synchronized switch value, read-only.
- IO_BASE+4: free-running cycle counter, read-only.
- IO_BASE+6: counter control; a write with data bit 0 = 1 clears the counter; reads return 0.
- All other addresses read 16'h0000 and ignore writes.
REQ-016 SHALL present read data on o_mem_rddata exactly one cycle after i_mem_rd is sampled high, for both RAM and I/O reads.
REQ-017 SHALL hold o_mem_rddata at its last value while i_mem_rd is low.
REQ-018 SHALL, when i_mem_rd and i_mem_wr are both high to the same location, complete the write and return the pre-write (old) value.
REQ-019 SHALL commit a write at the sampling edge; a read of the same location issued in the next cycle returns the new value.
REQ-020 SHALL increment the cycle counter by 1 every cycle and wrap from 16'hFFFF to 16'h0000.
REQ-021 SHALL, when a counter clear and the normal increment coincide, load the counter with 0 (clear wins).
REQ-022 SHALL pass i_sw through a two-flop synchronizer; reads of IO_BASE+2 return the second flop.
REQ-023 SHALL, while i_load_en = 1:
- write i_load_data to RAM word i_load_addr[15:1] every cycle;
- ignore i_mem_rd and i_mem_wr;
- hold o_mem_rddata unchanged.
REQ-024 SHALL ignore loader writes whose address is outside the RAM region.
REQ-025 SHALL drive o_led continuously from the LED register.

Reset
REQ-026 SHALL, on a reset edge, clear o_mem_rddata, the LED register, the cycle counter and both synchronizer stages to 0.
REQ-027 SHALL NOT clear RAM contents on reset.
REQ-028 SHALL give reset priority over any read, write or load sampled on the same edge; that request is dropped.
REQ-029 SHALL, when reset is asserted one cycle after a read request, return 0 on o_mem_rddata rather than the read data.

Structure
REQ-030 SHALL place IO_BASE offsets, the register-index enum and the RAM_WORDS default in the shared package mem_map_pkg.
REQ-031 SHALL implement RAM storage as one sub-module, ram_1rw_sync: single port, synchronous read, read-before-write, no reset.
REQ-032 SHALL contain the address decode, I/O registers, counter, synchronizer and response mux in mem_responder itself.

Verification
REQ-033 SHALL cover RAM write then read: write 16'hBEEF to 16'h0010, then read 16'h0010 next cycle -> o_mem_rddata = 16'hBEEF one cycle later; a read of 16'h0011 also returns 16'hBEEF.
REQ-034 SHALL cover simultaneous read and write: location 16'h0020 holds 16'h1234; rd+wr of 16'h5678 -> response 16'h1234; following read -> 16'h5678.
REQ-035 SHALL cover the cycle counter: after reset, read IO_BASE+4 at cycle 10 -> value 10 ±1 per documented latency; write 1 to IO_BASE+6 -> a subsequent read reflects the restart from 0; after 65536 cycles without a clear -> the counter has wrapped.
REQ-036 SHALL cover LED and switch: write 16'h00A5 to IO_BASE -> o_led = 16'h00A5 next cycle; set i_sw = 16'h0F0F -> a read of IO_BASE+2 issued three or more cycles later returns 16'h0F0F.
REQ-037 SHALL cover loader mode: load 16'h1111 and 16'h2222 at 16'h0000 and 16'h0002 with i_load_en = 1, while a CPU write to 16'h0000 is ignored; deassert load -> reads return 16'h1111 and 16'h2222.
REQ-038 SHALL cover reset mid-operation: a read issued, then reset the next cycle -> o_mem_rddata = 0, o_led = 0, counter = 0, and RAM contents are preserved.
